// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 receiver pin/result bundle: raw keyboard pins in, decoded key status out.
// Latency: none, wiring only.
// Backpressure: none; outputs are levels plus single-cycle pulses, nothing stalls.
// Ports: ps2_clk/ps2_data (raw pins), ps2_byte/ps2_state (held key),
//        byte_valid (per accepted frame), frame_err (per rejected frame).
interface ps2_keyboard_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] ps2_byte;
    logic       ps2_state;
    logic       byte_valid;
    logic       frame_err;

    // master: the receiver, which samples the pins and reports decoded keys
    modport master (
        input  ps2_clk,
        input  ps2_data,
        output ps2_byte,
        output ps2_state,
        output byte_valid,
        output frame_err
    );

    // slave: the pin driver / key parser side
    modport slave (
        output ps2_clk,
        output ps2_data,
        input  ps2_byte,
        input  ps2_state,
        input  byte_valid,
        input  frame_err
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronise + glitch-filter pins, deframe, decode make/break/E0.
// Latency: outputs update 1 clk after the filtered STOP edge (filtered edge trails the pin by 2+FILTER_LEN clk).
// Backpressure: none; byte_valid/frame_err are unqualified one-cycle pulses.
// Ports: clk, rst (sync, active-high); bus (master modport): ps2_clk, ps2_data in;
//        ps2_byte, ps2_state, byte_valid, frame_err out.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                  clk,
    input  logic                  rst,
    ps2_keyboard_rx_if.master     bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          break_pending;
    logic          ext;
    logic [7:0]    byte_q;
    logic          state_q;
    logic          vld_q;
    logic          err_q;

    // Pins idle high, so the synchronisers reset to 1 to avoid a fake edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= bus.ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= bus.ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it;
    // any agreeing sample restarts the count, so short pulses never get through.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // Cycle on which the filtered clock goes 1->0; data is sampled here.
    assign fall = filt_clk && !clk_s2 && (filt_cnt == FW'(FILTER_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shreg         <= '0;
            par_bit       <= 1'b0;
            to_cnt        <= '0;
            break_pending <= 1'b0;
            ext           <= 1'b0;
            byte_q        <= 8'h00;
            state_q       <= 1'b0;
            vld_q         <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            if (state == IDLE) begin
                to_cnt <= '0;
                if (fall && !dat_s2) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
            end else if (fall) begin
                to_cnt <= '0;
                case (state)
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= dat_s2;
                        state   <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (dat_s2 && (^{shreg, par_bit})) begin
                            vld_q <= 1'b1;
                            if (shreg == 8'hF0) begin
                                break_pending <= 1'b1;
                            end else if (shreg == 8'hE0) begin
                                ext <= 1'b1;
                            end else if (shreg == 8'hE1) begin
                                // pause-sequence prefix: counted, otherwise ignored
                            end else if (break_pending) begin
                                // release only matters for the key currently reported
                                if (shreg == byte_q) state_q <= 1'b0;
                                break_pending <= 1'b0;
                                ext           <= 1'b0;
                            end else begin
                                byte_q  <= shreg;
                                state_q <= 1'b1;
                                ext     <= 1'b0;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                endcase
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                // keyboard stopped clocking mid-frame: drop the partial byte
                state  <= IDLE;
                to_cnt <= '0;
                err_q  <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign bus.ps2_byte   = byte_q;
    assign bus.ps2_state  = state_q;
    assign bus.byte_valid = vld_q;
    assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: scoreboarded PS/2 frames, errors, timeout, glitches, reset.
// Latency: filtered edge trails the pin by 2+FILTER_LEN clk; outputs 1 clk later.
// Backpressure: none; the monitor pops one expectation per byte_valid pulse.
module tb_ps2_keyboard_rx;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF           = 20;   // PS/2 clock low/high phase in clk cycles
    localparam int QTR            = 10;   // data setup before the falling edge

    logic clk = 1'b0;
    logic rst = 1'b1;

    ps2_keyboard_rx_if bus();

    ps2_keyboard_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total    = 0;
    int bad      = 0;
    int vld_seen = 0;
    int err_seen = 0;

    logic [8:0] exp_q[$];   // {ps2_byte, ps2_state} expected at each byte_valid
    logic [7:0] m_byte;
    logic       m_state;
    logic       m_brk;
    logic       m_ext;

    // Scoreboard monitor, sampling on the falling clk edge.
    always @(negedge clk) begin
        if (bus.byte_valid === 1'b1) begin
            logic [8:0] e;
            vld_seen++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_byte_valid got byte=%h state=%b exp=none",
                         bus.ps2_byte, bus.ps2_state);
            end else begin
                e = exp_q.pop_front();
                if ({bus.ps2_byte, bus.ps2_state} !== e) begin
                    bad++;
                    $display("FAIL decode got byte=%h state=%b exp byte=%h state=%b",
                             bus.ps2_byte, bus.ps2_state, e[8:1], e[0]);
                end
            end
        end
        if (bus.frame_err === 1'b1) begin
            err_seen++;
            total++;
            if (bus.byte_valid !== 1'b0) begin
                bad++;
                $display("FAIL err_vld_overlap got byte_valid=%b exp=0", bus.byte_valid);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_byte  = 8'h00;
        m_state = 1'b0;
        m_brk   = 1'b0;
        m_ext   = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hE1) begin end
        else if (m_brk) begin
            if (b == m_byte) m_state = 1'b0;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            m_byte  = b;
            m_state = 1'b1;
            m_ext   = 1'b0;
        end
        exp_q.push_back({m_byte, m_state});
    endtask

    // One bit cell: data set while clock high, optional 3-cycle low glitch, fall, rise.
    task automatic drive_bit(input logic v, input bit glitch);
        bus.ps2_data = v;
        if (glitch) begin
            wait_cyc(3);
            bus.ps2_clk = 1'b0;
            wait_cyc(3);
            bus.ps2_clk = 1'b1;
            wait_cyc(QTR - 6);
        end else begin
            wait_cyc(QTR);
        end
        bus.ps2_clk = 1'b0;
        wait_cyc(HALF);
        bus.ps2_clk = 1'b1;
        wait_cyc(QTR);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = (~^b) ^ bad_par;
        return {1'b1, p, b, 1'b0};   // bit 0 = start, sent first
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int glitch_bit,
                              input int gap);
        logic [10:0] f;
        f = make_frame(b, bad_par);
        for (int i = 0; i < 11; i++) begin
            if (i == 10 && !bad_par) model_accept(b);
            drive_bit(f[i], glitch_bit == i);
        end
        if (gap > 0) wait_cyc(gap);
    endtask

    task automatic check_after(input string name, input int v0, input int nv, input int e0,
                               input int ne, input logic [7:0] eb, input logic es);
        total++;
        if (vld_seen - v0 !== nv) begin
            bad++;
            $display("FAIL %s_vld_count got=%0d exp=%0d", name, vld_seen - v0, nv);
        end
        total++;
        if (err_seen - e0 !== ne) begin
            bad++;
            $display("FAIL %s_err_count got=%0d exp=%0d", name, err_seen - e0, ne);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_output got=%0d pending exp=0", name, exp_q.size());
        end
        total++;
        if (bus.ps2_byte !== eb || bus.ps2_state !== es) begin
            bad++;
            $display("FAIL %s_outputs got byte=%h state=%b exp byte=%h state=%b",
                     name, bus.ps2_byte, bus.ps2_state, eb, es);
        end
    endtask

    task automatic test_reset();
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        model_reset();
        wait_cyc(5);
        total++;
        if ({bus.ps2_byte, bus.ps2_state, bus.byte_valid, bus.frame_err} !== 11'h000) begin
            bad++;
            $display("FAIL reset_outputs got byte=%h state=%b vld=%b err=%b exp all 0",
                     bus.ps2_byte, bus.ps2_state, bus.byte_valid, bus.frame_err);
        end
        rst = 1'b0;
        wait_cyc(5);
    endtask

    task automatic test_make();
        int v0 = vld_seen, e0 = err_seen;
        send_frame(8'h1D, 1'b0, -1, 20);
        check_after("make", v0, 1, e0, 0, 8'h1D, 1'b1);
    endtask

    task automatic test_break();
        int v0 = vld_seen, e0 = err_seen;
        send_frame(8'hF0, 1'b0, -1, 20);
        send_frame(8'h1D, 1'b0, -1, 20);
        check_after("break", v0, 2, e0, 0, 8'h1D, 1'b0);
    endtask

    task automatic test_extended();
        int v0 = vld_seen, e0 = err_seen;
        send_frame(8'hE0, 1'b0, -1, 20);
        send_frame(8'h75, 1'b0, -1, 20);
        check_after("ext_make", v0, 2, e0, 0, 8'h75, 1'b1);
        v0 = vld_seen;
        send_frame(8'hE0, 1'b0, -1, 20);
        send_frame(8'hF0, 1'b0, -1, 20);
        send_frame(8'h75, 1'b0, -1, 20);
        check_after("ext_break", v0, 3, e0, 0, 8'h75, 1'b0);
        v0 = vld_seen;
        send_frame(8'h1D, 1'b0, -1, 20);
        send_frame(8'hF0, 1'b0, -1, 20);
        send_frame(8'h23, 1'b0, -1, 20);
        check_after("other_break", v0, 3, e0, 0, 8'h1D, 1'b1);
        v0 = vld_seen;
        send_frame(8'hE1, 1'b0, -1, 20);
        check_after("e1_discard", v0, 1, e0, 0, 8'h1D, 1'b1);
    endtask

    task automatic test_typematic();
        int v0 = vld_seen, e0 = err_seen;
        send_frame(8'h1D, 1'b0, -1, 20);
        send_frame(8'h1D, 1'b0, -1, 20);
        check_after("typematic", v0, 2, e0, 0, 8'h1D, 1'b1);
        v0 = vld_seen;
        send_frame(8'h23, 1'b0, -1, 20);
        check_after("new_make", v0, 1, e0, 0, 8'h23, 1'b1);
    endtask

    task automatic test_parity_err();
        int v0, e0;
        send_frame(8'h1D, 1'b0, -1, 20);
        v0 = vld_seen;
        e0 = err_seen;
        send_frame(8'h23, 1'b1, -1, 20);
        check_after("parity_err", v0, 0, e0, 1, 8'h1D, 1'b1);
        v0 = vld_seen;
        e0 = err_seen;
        send_frame(8'h23, 1'b0, -1, 20);
        check_after("parity_recover", v0, 1, e0, 0, 8'h23, 1'b1);
    endtask

    task automatic test_timeout();
        int v0 = vld_seen, e0 = err_seen;
        int found = 0;
        int budget = TIMEOUT_CYCLES + 200;
        logic [10:0] f;
        f = make_frame(8'h29, 1'b0);
        for (int i = 0; i < 5; i++) drive_bit(f[i], 1'b0);   // start + 4 data bits
        bus.ps2_data = f[5];
        wait_cyc(QTR);
        bus.ps2_clk = 1'b0;                                   // 5th data bit: last edge
        for (int k = 1; k <= budget && found == 0; k++) begin
            @(posedge clk);
            #1;
            if (k == HALF) bus.ps2_clk = 1'b1;
            @(negedge clk);
            if (bus.frame_err === 1'b1) found = k;
        end
        total++;
        if (found !== TIMEOUT_CYCLES + FILTER_LEN + 2) begin
            bad++;
            $display("FAIL timeout_latency got=%0d exp=%0d (0 = never)",
                     found, TIMEOUT_CYCLES + FILTER_LEN + 2);
        end
        bus.ps2_data = 1'b1;
        wait_cyc(20);
        check_after("timeout", v0, 0, e0, 1, 8'h23, 1'b1);
        v0 = vld_seen;
        e0 = err_seen;
        send_frame(8'h29, 1'b0, -1, 20);
        check_after("timeout_recover", v0, 1, e0, 0, 8'h29, 1'b1);
    endtask

    task automatic test_glitch();
        int v0 = vld_seen, e0 = err_seen;
        bus.ps2_clk = 1'b0;           // idle glitch
        wait_cyc(3);
        bus.ps2_clk = 1'b1;
        wait_cyc(30);
        send_frame(8'h4B, 1'b0, 3, 20);
        send_frame(8'hF0, 1'b0, 9, 20);
        send_frame(8'h4B, 1'b0, 1, 20);
        check_after("glitch", v0, 3, e0, 0, 8'h4B, 1'b0);
    endtask

    task automatic test_rst_midframe();
        int v0, e0;
        logic [10:0] f;
        send_frame(8'h1D, 1'b0, -1, 20);
        f = make_frame(8'h5A, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(f[i], 1'b0);   // start + 3 data bits
        rst = 1'b1;
        wait_cyc(1);
        total++;
        if ({bus.ps2_byte, bus.ps2_state, bus.byte_valid, bus.frame_err} !== 11'h000) begin
            bad++;
            $display("FAIL rst_mid_outputs got byte=%h state=%b vld=%b err=%b exp all 0",
                     bus.ps2_byte, bus.ps2_state, bus.byte_valid, bus.frame_err);
        end
        rst = 1'b0;
        model_reset();
        v0 = vld_seen;
        e0 = err_seen;
        for (int i = 4; i < 11; i++) drive_bit(f[i], 1'b0);   // tail of the broken frame
        wait_cyc(TIMEOUT_CYCLES + 200);
        total++;
        if (err_seen - e0 > 1) begin
            bad++;
            $display("FAIL rst_mid_err_count got=%0d exp<=1", err_seen - e0);
        end
        total++;
        if (vld_seen != v0) begin
            bad++;
            $display("FAIL rst_mid_vld_count got=%0d exp=0", vld_seen - v0);
        end
        v0 = vld_seen;
        e0 = err_seen;
        send_frame(8'h1D, 1'b0, -1, 20);
        check_after("rst_recover", v0, 1, e0, 0, 8'h1D, 1'b1);
    endtask

    task automatic test_back_to_back();
        int v0 = vld_seen, e0 = err_seen;
        send_frame(8'h1B, 1'b0, -1, 0);
        send_frame(8'hF0, 1'b0, -1, 0);
        send_frame(8'h1B, 1'b0, -1, 0);
        send_frame(8'h75, 1'b0, -1, 20);
        check_after("back_to_back", v0, 4, e0, 0, 8'h75, 1'b1);
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_typematic();
        test_parity_err();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_rst_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
